// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmitter and keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    XFER,
    WAIT_IDLE,
    ERR
  } ps2_state_t;

  typedef logic [7:0] ps2_byte_t;

  localparam ps2_byte_t PS2_CMD_SET_LED = 8'hED;
  localparam ps2_byte_t PS2_CMD_ENABLE  = 8'hF4;
  localparam ps2_byte_t PS2_CMD_RESET   = 8'hFF;
  localparam ps2_byte_t PS2_ACK         = 8'hFA;

  // Device clock falling edges seen in one host-to-device frame (10 bits out + ack).
  localparam int unsigned PS2_FRAME_FALLS = 11;

  // Odd parity: the parity bit makes the count of ones over data+parity odd.
  function automatic logic ps2_odd_parity(input ps2_byte_t b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request/status handshake between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic      tx_valid;
  ps2_byte_t tx_data;
  logic      tx_ready;
  logic      tx_busy;
  logic      tx_done;
  logic      tx_err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_busy, tx_done, tx_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_busy, tx_done, tx_err
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// Three-flop synchroniser with falling-edge strobe for one PS/2 line.
// Flops reset to 1 so an idle (pulled-up) line never produces a spurious fall.
module ps2_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic pin,
  output logic level,
  output logic fall_c
);

  logic [2:0] sync_q;

  // Shift the asynchronous pin level through three flops; sync_q[0] is the newest.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], pin};
    end
  end

  assign level  = sync_q[2];
  assign fall_c = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues the start bit, then
// shifts one byte plus odd parity and stop out on device clock falls and checks the ack.
// Optional build macro: PS2_TX_RETRY_EN (retry a NACK/timeout up to twice before tx_err).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TMR_W          = 20
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  ps2_host_tx_if.slave tx,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int unsigned BIT_W = 4;
  localparam logic [BIT_W-1:0] ACK_FALL  = BIT_W'(PS2_FRAME_FALLS - 1);
  localparam logic [BIT_W-1:0] STOP_FALL = BIT_W'(PS2_FRAME_FALLS - 2);
  localparam logic [BIT_W-1:0] PAR_FALL  = BIT_W'(PS2_FRAME_FALLS - 3);
  localparam logic [TMR_W-1:0] INH_LAST  = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state_q;
  ps2_byte_t        byte_q;
  logic             par_q;
  logic [BIT_W-1:0] bit_q;
  logic [TMR_W-1:0] tmr_q;

`ifdef PS2_TX_RETRY_EN
  localparam logic [1:0] MAX_RETRY = 2'd2;
  logic [1:0] retry_q;
`endif

  logic clk_level;
  logic clk_fall_c;
  logic data_level;
  logic data_fall_unused;

  ps2_sync_edge u_sync_clk (
    .clk    (clk),
    .resetn (resetn),
    .pin    (ps2_clk_in),
    .level  (clk_level),
    .fall_c (clk_fall_c)
  );

  ps2_sync_edge u_sync_data (
    .clk    (clk),
    .resetn (resetn),
    .pin    (ps2_data_in),
    .level  (data_level),
    .fall_c (data_fall_unused)
  );

  logic tmo_c;
  logic fail_c;
  logic next_bit_c;

  // Abort conditions (NACK on the ack fall, or no device activity) and the next bit to drive.
  always_comb begin
    tmo_c      = (tmr_q == TMO_LAST);
    fail_c     = 1'b0;
    next_bit_c = byte_q[bit_q[2:0]];
    if (bit_q == PAR_FALL) begin
      next_bit_c = par_q;
    end
    if (state_q == XFER) begin
      fail_c = clk_fall_c ? ((bit_q == ACK_FALL) && data_level) : tmo_c;
    end else if (state_q == WAIT_IDLE) begin
      fail_c = !(clk_level && data_level) && !clk_fall_c && tmo_c;
    end
  end

  // Transmit sequencer with registered line enables and status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      par_q       <= 1'b0;
      bit_q       <= '0;
      tmr_q       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx.tx_ready <= 1'b1;
      tx.tx_busy  <= 1'b0;
      tx.tx_done  <= 1'b0;
      tx.tx_err   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      tx.tx_done <= 1'b0;
      tx.tx_err  <= 1'b0;
      if (fail_c) begin
`ifdef PS2_TX_RETRY_EN
        if (retry_q != MAX_RETRY) begin
          // Restart the whole frame with the byte still held in byte_q.
          retry_q     <= retry_q + 2'd1;
          state_q     <= INHIBIT;
          ps2_clk_oe  <= 1'b1;
          ps2_data_oe <= 1'b0;
          tmr_q       <= '0;
          bit_q       <= '0;
        end else begin
          state_q     <= ERR;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx.tx_err   <= 1'b1;
        end
`else
        state_q     <= ERR;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx.tx_err   <= 1'b1;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (tx.tx_valid) begin
              byte_q      <= tx.tx_data;
              par_q       <= ps2_odd_parity(tx.tx_data);
              state_q     <= INHIBIT;
              tx.tx_ready <= 1'b0;
              tx.tx_busy  <= 1'b1;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= 1'b0;
              tmr_q       <= '0;
              bit_q       <= '0;
`ifdef PS2_TX_RETRY_EN
              retry_q     <= '0;
`endif
            end
          end

          INHIBIT: begin
            if (tmr_q == INH_LAST) begin
              state_q     <= START;
              ps2_data_oe <= 1'b1;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end

          START: begin
            state_q    <= XFER;
            ps2_clk_oe <= 1'b0;
            bit_q      <= '0;
            tmr_q      <= '0;
          end

          XFER: begin
            if (clk_fall_c) begin
              bit_q <= bit_q + BIT_W'(1);
              tmr_q <= '0;
              if (bit_q == ACK_FALL) begin
                state_q <= WAIT_IDLE;
              end else if (bit_q == STOP_FALL) begin
                ps2_data_oe <= 1'b0;
              end else begin
                ps2_data_oe <= ~next_bit_c;
              end
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end

          WAIT_IDLE: begin
            if (clk_level && data_level) begin
              state_q     <= IDLE;
              tx.tx_done  <= 1'b1;
              tx.tx_ready <= 1'b1;
              tx.tx_busy  <= 1'b0;
            end else if (clk_fall_c) begin
              tmr_q <= '0;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end

          ERR: begin
            state_q     <= IDLE;
            tx.tx_ready <= 1'b1;
            tx.tx_busy  <= 1'b0;
          end

          default: begin
            state_q     <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx.tx_ready <= 1'b1;
            tx.tx_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
